// File: rtl/fir_coef_loader.sv
// fir_coef_loader: collects FIR taps over valid/ready and expands them into 8 DA LUTs (option FIR_COEF_SYMMETRIC_EN)
module fir_coef_loader #(
  parameter int TAP_W   = 16,
  parameter int CIN_W   = 19,
  parameter int CADDR_W = 11,
  parameter int GAP     = 0
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [TAP_W-1:0]   tap_in,
  input  logic               tap_valid,
  output logic               tap_ready,
  output logic [CIN_W-1:0]   CIN,
  output logic [CADDR_W-1:0] CADDR,
  output logic               CLOAD,
  output logic               busy,
  output logic               done
);
`ifdef FIR_COEF_SYMMETRIC_EN
  localparam int NT = 32;
`else
  localparam int NT = 64;
`endif
  localparam int CW = $clog2(NT);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [1:0] IDLE = 2'd0, COLLECT = 2'd1, GEN = 2'd2, DONE = 2'd3;
  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CADDR_W:0]   idx_q, idx_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic [CIN_W-1:0]   cin_q, cin_d;
  logic [CADDR_W-1:0] caddr_q, caddr_d;
  logic               cload_q, cload_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [TAP_W-1:0]   tap_q [NT];
  logic [TAP_W-1:0]   t_v;
  logic [CIN_W-1:0]   sum;
  assign tap_ready = state_q != GEN;
  assign CIN       = cin_q;
  assign CADDR     = caddr_q;
  assign CLOAD     = cload_q;
  assign busy      = busy_q;
  assign done      = done_q;
  // Symmetric builds hold only the lower half; tap[63-k] folds onto slot k.
  function automatic logic [TAP_W-1:0] tap_at(input logic [5:0] t);
`ifdef FIR_COEF_SYMMETRIC_EN
    return t[5] ? tap_q[~t[4:0]] : tap_q[t[4:0]];
`else
    return tap_q[t];
`endif
  endfunction
  // LUT entry for the current write index: sum of the sign-extended taps selected by the address bits
  always_comb begin
    sum = '0;
    t_v = '0;
    for (int i = 0; i < 8; i++) begin
      t_v = tap_at({idx_q[CADDR_W-1 -: 3], 3'(i)});
      sum = idx_q[i] ? sum + {{(CIN_W - TAP_W){t_v[TAP_W-1]}}, t_v} : sum;
    end
  end
  // Next state: tap handshake, FSM progression and paced LUT write issue
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    cload_d = 1'b0;
    caddr_d = caddr_q;
    cin_d   = cin_q;
    busy_d  = busy_q;
    done_d  = done_q;
    if (tap_ready && tap_valid) begin
      state_d = (cnt_q == CW'(NT - 1)) ? GEN : COLLECT;
      cnt_d   = (cnt_q == CW'(NT - 1)) ? '0 : cnt_q + 1'b1;
      idx_d   = '0;
      gap_d   = '0;
      done_d  = 1'b0;
    end else if (state_q == GEN) begin
      if (idx_q[CADDR_W]) begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else if (gap_q == '0) begin
        cload_d = 1'b1;
        caddr_d = idx_q[CADDR_W-1:0];
        cin_d   = sum;
        busy_d  = 1'b1;
        idx_d   = idx_q + 1'b1;
        gap_d   = GW'(GAP);
      end else begin
        gap_d = gap_q - 1'b1;
      end
    end
  end
  // Control and output registers; reset abandons any write sequence in flight
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      cload_q <= 1'b0;
      caddr_q <= '0;
      cin_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      cload_q <= cload_d;
      caddr_q <= caddr_d;
      cin_q   <= cin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  // Tap store: only accepted transfers land, in arrival order
  always_ff @(posedge clk) begin
    if (tap_ready && tap_valid) tap_q[cnt_q] <= tap_in;
  end
endmodule

// File: tb/tb_fir_coef_loader.sv
// tb_fir_coef_loader: directed checks of tap upload, LUT expansion, pacing, handshake and abort
module tb_fir_coef_loader;
`ifdef FIR_COEF_SYMMETRIC_EN
  localparam int NT = 32;
`else
  localparam int NT = 64;
`endif
  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] tap_in;
  logic        tap_valid;
  logic        tap_ready0, tap_ready1;
  logic [18:0] CIN0, CIN1;
  logic [10:0] CADDR0, CADDR1;
  logic        CLOAD0, CLOAD1, busy0, busy1, done0, done1;
  int          n_chk = 0, n_fail = 0;
  int          tv [64];
  int          mt [64];
  logic [18:0] seen [2048];
  fir_coef_loader dut0 (
    .clk(clk), .resetn(resetn), .tap_in(tap_in), .tap_valid(tap_valid), .tap_ready(tap_ready0),
    .CIN(CIN0), .CADDR(CADDR0), .CLOAD(CLOAD0), .busy(busy0), .done(done0)
  );
  fir_coef_loader #(.GAP(2)) dut1 (
    .clk(clk), .resetn(resetn), .tap_in(tap_in), .tap_valid(tap_valid), .tap_ready(tap_ready1),
    .CIN(CIN1), .CADDR(CADDR1), .CLOAD(CLOAD1), .busy(busy1), .done(done1)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask
  task automatic set_model();
    for (int t = 0; t < 64; t++) mt[t] = (NT == 32 && t >= 32) ? tv[63 - t] : tv[t];
  endtask
  function automatic logic [18:0] exp_cin(input logic [10:0] a);
    int s = 0;
    for (int i = 0; i < 8; i++) if (a[i]) s += mt[{a[10:8], 3'(i)}];
    return 19'(s);
  endfunction
  task automatic upload(input int first, input int last, input bit rnd, input bit hold, input bit clr);
    int k = first;
    int cyc = 0;
    bit pend = 0;
    while (k < last && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (pend) begin
        check("done_clr", done0, 0);
        pend = 0;
      end
      tap_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tap_in = tap_valid ? 16'(tv[k]) : 16'h5a5a;
      if (tap_valid && tap_ready0) begin
        pend = clr && k == first;
        k++;
      end
    end
    check("upload_cnt", k, last);
    @(negedge clk);
    if (pend) check("done_clr", done0, 0);
    tap_valid = hold;
    tap_in = 16'h7fff;
  endtask
  task automatic run_gen(input bit hold);
    int n0 = 0, n1 = 0, bad0 = 0, bad1 = 0, hole0 = 0, rdy0 = 0, rdy1 = 0, gapbad = 0, idle1 = 0, cyc = 0;
    bit d0 = 0, d1 = 0, prev0 = 0, prev1 = 0;
    check("e0_ready", tap_ready0, 0);
    check("e0_cload", CLOAD0, 0);
    check("e0_busy", busy0, 0);
    @(negedge clk);
    check("first_cload", CLOAD0, 1);
    check("first_caddr", CADDR0, 0);
    check("first_busy", busy0, 1);
    check("first_cload_gap", CLOAD1, 1);
    while (!(d0 && d1) && cyc < 7000) begin
      if (!d0) begin
        if (done0) begin
          d0 = 1;
          check("done0_cnt", n0, 2048);
          check("done0_prev", prev0, 1);
          check("done0_cload", CLOAD0, 0);
          check("done0_busy", busy0, 0);
          tap_valid = 1'b0;
        end else begin
          prev0 = CLOAD0;
          if (CLOAD0) begin
            if (int'(CADDR0) != n0 || CIN0 != exp_cin(CADDR0)) bad0++;
            seen[CADDR0] = CIN0;
            n0++;
          end else hole0++;
          if (!busy0 || tap_ready0) rdy0++;
        end
      end
      if (!d1) begin
        if (done1) begin
          d1 = 1;
          check("done1_cnt", n1, 2048);
          check("done1_prev", prev1, 1);
          check("done1_busy", busy1, 0);
        end else begin
          prev1 = CLOAD1;
          if (CLOAD1) begin
            if (int'(CADDR1) != n1 || CIN1 != exp_cin(CADDR1)) bad1++;
            if (n1 > 0 && idle1 != 2) gapbad++;
            idle1 = 0;
            n1++;
          end else idle1++;
          if (!busy1 || tap_ready1) rdy1++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    check("gen_end", d0 && d1, 1);
    check("seq0_bad", bad0, 0);
    check("seq0_holes", hole0, 0);
    check("busy0_ready0", rdy0, 0);
    check("seq1_bad", bad1, 0);
    check("gap1_bad", gapbad, 0);
    check("busy1_ready1", rdy1, 0);
    check("done_level", done0, 1);
  endtask
  initial begin
    int cyc, bad;
    resetn = 1'b0;
    tap_valid = 1'b0;
    tap_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cload", CLOAD0, 0);
    check("rst_caddr", CADDR0, 0);
    check("rst_cin", CIN0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_ready", tap_ready0, 1);
    for (int k = 0; k < 64; k++) tv[k] = 1;
    set_model();
    upload(0, NT, 0, 0, 0);
    run_gen(0);
    check("t2_0ff", seen[11'h0ff], 8);
    check("t2_401", seen[11'h401], 1);
    for (int k = 0; k < 64; k++) tv[k] = -32768;
    set_model();
    upload(0, NT, 0, 0, 1);
    run_gen(0);
    check("t3_0ff", seen[11'h0ff], 19'h40000);
    check("t3_001", seen[11'h001], 19'h78000);
    for (int k = 0; k < 64; k++) tv[k] = k;
    set_model();
    upload(0, NT, 1, 1, 1);
    run_gen(1);
    check("t4_205", seen[11'h205], 34);
`ifdef FIR_COEF_SYMMETRIC_EN
    check("t4_780", seen[11'h780], 0);
`else
    check("t4_780", seen[11'h780], 63);
`endif
    for (int k = 0; k < 64; k++) tv[k] = k * 3 - 100;
    set_model();
    upload(0, NT, 0, 0, 1);
    cyc = 0;
    while (!(CLOAD0 && CADDR0 == 11'd100) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_reach", CADDR0, 100);
    resetn = 1'b0;
    @(negedge clk);
    check("abort_cload", CLOAD0, 0);
    check("abort_busy", busy0, 0);
    check("abort_caddr", CADDR0, 0);
    check("abort_done", done0, 0);
    resetn = 1'b1;
    @(negedge clk);
    check("abort_ready", tap_ready0, 1);
    upload(0, NT - 1, 0, 0, 0);
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (CLOAD0 || busy0 || CLOAD1 || busy1 || !tap_ready0) bad++;
    end
    check("partial_idle", bad, 0);
    upload(NT - 1, NT, 0, 0, 0);
    run_gen(0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
